// File: rtl/fma16_arbiter.sv
// fma16_arbiter: round-robin sharing of one fma16 datapath; FMA16_ARB_STATS_EN adds stat_ops/stat_busy counters.
// Latency LAT+1 cycles handshake-to-resp_valid (1 for an illegal op); all requesters stall while a response waits on resp_ready.
module fma16_arbiter #(
    parameter int NREQ = 2,
    parameter int LAT  = 1,
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [16*NREQ-1:0]   req_x,
    input  logic [16*NREQ-1:0]   req_y,
    input  logic [16*NREQ-1:0]   req_z,
    input  logic [3*NREQ-1:0]    req_op,
    input  logic [2*NREQ-1:0]    req_rm,
    output logic [15:0]          fma_x,
    output logic [15:0]          fma_y,
    output logic [15:0]          fma_z,
    output logic                 fma_mul,
    output logic                 fma_add,
    output logic                 fma_negr,
    output logic                 fma_negz,
    output logic [1:0]           fma_rm,
    input  logic [15:0]          fma_result,
    input  logic [3:0]           fma_flags,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [IDW-1:0]       resp_id,
    output logic [15:0]          resp_result,
    output logic [3:0]           resp_flags,
    output logic                 resp_err
`ifdef FMA16_ARB_STATS_EN
    ,
    output logic [15:0]          stat_ops,
    output logic [15:0]          stat_busy
`endif
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t         state;
    logic [IDW-1:0] last_grant;
    logic [3:0]     cnt;

    logic           found;
    logic [IDW-1:0] win;
    int             win_i;
    int             idx;
    logic [15:0]    sel_x, sel_y, sel_z;
    logic [2:0]     sel_op;
    logic [1:0]     sel_rm;
    logic [4:0]     dec;

    // {illegal, mul, add, negr, negz}
    function automatic logic [4:0] decode(input logic [2:0] op);
        case (op)
            3'b000:  return 5'b0_0100;
            3'b001:  return 5'b0_0101;
            3'b010:  return 5'b0_1000;
            3'b100:  return 5'b0_1100;
            3'b101:  return 5'b0_1101;
            3'b110:  return 5'b0_1110;
            3'b111:  return 5'b0_1111;
            default: return 5'b1_0000;
        endcase
    endfunction

    // Search upward from last_grant+1 so the most recent winner has lowest priority.
    always_comb begin
        found = 1'b0;
        win   = '0;
        win_i = 0;
        idx   = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last_grant) + k) % NREQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win_i = idx;
                win   = IDW'(idx);
            end
        end
        sel_x  = req_x[16*win_i +: 16];
        sel_y  = req_y[16*win_i +: 16];
        sel_z  = req_z[16*win_i +: 16];
        sel_op = req_op[3*win_i +: 3];
        sel_rm = req_rm[2*win_i +: 2];
        dec    = decode(sel_op);
        req_ready = '0;
        if (state == IDLE && found)
            req_ready = NREQ'(1) << win_i;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            last_grant  <= IDW'(NREQ - 1);
            cnt         <= '0;
            fma_x       <= '0;
            fma_y       <= '0;
            fma_z       <= '0;
            fma_mul     <= 1'b0;
            fma_add     <= 1'b0;
            fma_negr    <= 1'b0;
            fma_negz    <= 1'b0;
            fma_rm      <= '0;
            resp_valid  <= 1'b0;
            resp_id     <= '0;
            resp_result <= '0;
            resp_flags  <= '0;
            resp_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        fma_x      <= sel_x;
                        fma_y      <= sel_y;
                        fma_z      <= sel_z;
                        {fma_mul, fma_add, fma_negr, fma_negz} <= dec[3:0];
                        fma_rm     <= sel_rm;
                        resp_id    <= win;
                        last_grant <= win;
                        cnt        <= 4'(LAT - 1);
                        if (dec[4]) begin
                            resp_err    <= 1'b1;
                            resp_result <= '0;
                            resp_flags  <= '0;
                            resp_valid  <= 1'b1;
                            state       <= RESP;
                        end else begin
                            state <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    if (cnt == 4'd0) begin
                        resp_result <= fma_result;
                        resp_flags  <= fma_flags;
                        resp_err    <= 1'b0;
                        resp_valid  <= 1'b1;
                        state       <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FMA16_ARB_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_ops  <= '0;
            stat_busy <= '0;
        end else begin
            if (state == RESP && resp_ready && stat_ops != 16'hFFFF)
                stat_ops <= stat_ops + 16'd1;
            if (state != IDLE && stat_busy != 16'hFFFF)
                stat_busy <= stat_busy + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fma16_arbiter.sv
// Randomized bench for fma16_arbiter against a transaction-level round-robin model and a cycle-dependent stub datapath.
module tb_fma16_arbiter;
    localparam int NREQ = 3;
    localparam int LAT  = 3;
    localparam int IDW  = 2;
    localparam int NTXN = 300;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [16*NREQ-1:0]   req_x, req_y, req_z;
    logic [3*NREQ-1:0]    req_op;
    logic [2*NREQ-1:0]    req_rm;
    logic [15:0]          fma_x, fma_y, fma_z;
    logic                 fma_mul, fma_add, fma_negr, fma_negz;
    logic [1:0]           fma_rm;
    logic [15:0]          fma_result;
    logic [3:0]           fma_flags;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [IDW-1:0]       resp_id;
    logic [15:0]          resp_result;
    logic [3:0]           resp_flags;
    logic                 resp_err;
`ifdef FMA16_ARB_STATS_EN
    logic [15:0]          stat_ops, stat_busy;
`endif

    logic [15:0] rx [NREQ];
    logic [15:0] ry [NREQ];
    logic [15:0] rz [NREQ];
    logic [2:0]  rop[NREQ];
    logic [1:0]  rrm[NREQ];
    logic        rvld[NREQ];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int mlast;
    int m_ops   = 0;
    int m_busy  = 0;

    fma16_arbiter #(.NREQ(NREQ), .LAT(LAT)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y), .req_z(req_z),
        .req_op(req_op), .req_rm(req_rm),
        .fma_x(fma_x), .fma_y(fma_y), .fma_z(fma_z),
        .fma_mul(fma_mul), .fma_add(fma_add), .fma_negr(fma_negr), .fma_negz(fma_negz),
        .fma_rm(fma_rm), .fma_result(fma_result), .fma_flags(fma_flags),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_result(resp_result), .resp_flags(resp_flags), .resp_err(resp_err)
`ifdef FMA16_ARB_STATS_EN
        , .stat_ops(stat_ops), .stat_busy(stat_busy)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stub datapath: output depends on operands, controls and the current cycle.
    function automatic logic [15:0] stub_res(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z,
                                             input logic [3:0] ctl, input logic [1:0] rm, input logic [15:0] c);
        return x + (y ^ {z[7:0], z[15:8]}) + {ctl, rm, 10'd0} + c * 16'd7;
    endfunction

    function automatic logic [3:0] stub_flg(input logic [15:0] z, input logic [3:0] ctl, input logic [15:0] c);
        return z[3:0] ^ c[3:0] ^ ctl;
    endfunction

    function automatic logic [3:0] exp_ctl(input logic [2:0] op);
        case (op)
            3'd0: return 4'b0100;
            3'd1: return 4'b0101;
            3'd2: return 4'b1000;
            3'd4: return 4'b1100;
            3'd5: return 4'b1101;
            3'd6: return 4'b1110;
            3'd7: return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    always_comb begin
        fma_result = stub_res(fma_x, fma_y, fma_z, {fma_mul, fma_add, fma_negr, fma_negz}, fma_rm, 16'(cyc));
        fma_flags  = stub_flg(fma_z, {fma_mul, fma_add, fma_negr, fma_negz}, 16'(cyc));
    end

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]         = rvld[i];
            req_x[16*i +: 16]    = rx[i];
            req_y[16*i +: 16]    = ry[i];
            req_z[16*i +: 16]    = rz[i];
            req_op[3*i +: 3]     = rop[i];
            req_rm[2*i +: 2]     = rrm[i];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic new_req(input int i);
        rx[i]   = 16'($urandom);
        ry[i]   = 16'($urandom);
        rz[i]   = 16'($urandom);
        rop[i]  = 3'($urandom_range(0, 7));
        rrm[i]  = 2'($urandom_range(0, 3));
        rvld[i] = 1'b1;
    endtask

    // One arbitration opportunity in IDLE; if granted, follows it through to the response handshake.
    task automatic do_txn(input int hold);
        int w;
        int c;
        int wait_cyc;
        logic illegal;
        logic [15:0] ex, ey, ez, e_res;
        logic [3:0]  e_flg;
        logic [2:0]  eop;
        logic [1:0]  erm;
        w = -1;
        @(negedge clk);
        for (int k = 1; k <= NREQ; k++)
            if (w < 0 && rvld[(mlast + k) % NREQ]) w = (mlast + k) % NREQ;
        if (w < 0) begin
            check("ready_none", 32'(req_ready), 32'd0);
            @(posedge clk); #1;
            return;
        end
        check("grant", 32'(req_ready), 32'd1 << w);
        ex = rx[w]; ey = ry[w]; ez = rz[w]; eop = rop[w]; erm = rrm[w];
        c = cyc;
        illegal = (eop == 3'd3);
        @(posedge clk); #1;
        mlast   = w;
        rvld[w] = 1'b0;
        wait_cyc = illegal ? 1 : LAT + 1;
        for (int k = 1; k < wait_cyc; k++) begin
            @(negedge clk);
            check("busy_quiet", {30'd0, resp_valid, |req_ready}, 32'd0);
            @(posedge clk); #1;
            if ($urandom_range(0, 3) == 0) new_req($urandom_range(0, NREQ - 1));
        end
        if (illegal) begin
            e_res = 16'd0;
            e_flg = 4'd0;
        end else begin
            e_res = stub_res(ex, ey, ez, exp_ctl(eop), erm, 16'(c + LAT));
            e_flg = stub_flg(ez, exp_ctl(eop), 16'(c + LAT));
        end
        for (int h = 0; h <= hold; h++) begin
            resp_ready = (h == hold);
            @(negedge clk);
            check("resp_valid", 32'(resp_valid), 32'd1);
            check("resp_id", 32'(resp_id), 32'(w));
            check("resp_result", 32'(resp_result), 32'(e_res));
            check("resp_flags", 32'(resp_flags), 32'(e_flg));
            check("resp_err", 32'(resp_err), 32'(illegal));
            check("resp_no_grant", 32'(req_ready), 32'd0);
            @(posedge clk); #1;
        end
        resp_ready = 1'b0;
        m_ops++;
        m_busy += (illegal ? 0 : LAT) + hold + 1;
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            rx[i] = '0; ry[i] = '0; rz[i] = '0; rop[i] = '0; rrm[i] = '0; rvld[i] = 1'b0;
        end
        resp_ready = 1'b0;
        reset_n    = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_fields", {11'd0, resp_id, resp_result, resp_flags, resp_err}, 32'd0);
        check("rst_fma_ops", {fma_x, fma_y}, 32'd0);
        check("rst_fma_ctl", {25'd0, fma_z == 16'd0, fma_mul, fma_add, fma_negr, fma_negz, fma_rm}, 32'd64);
        check("rst_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        mlast   = NREQ - 1;

        // Abort an operation with reset mid-EXEC; requester 0 must win first after reset.
        new_req(0);
        rop[0] = 3'd4;
        @(negedge clk);
        check("abort_grant", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        rvld[0] = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("abort_resp", {resp_valid, resp_err, resp_result, resp_flags}, 32'd0);
        check("abort_fma", 32'(fma_x), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        mlast   = NREQ - 1;
        for (int k = 0; k < 2 * LAT + 3; k++) begin
            @(negedge clk);
            check("abort_no_resp", {30'd0, resp_valid, |req_ready}, 32'd0);
        end
        @(posedge clk); #1;

        // Directed: all requesters continuously valid with legal ops -> grants rotate 0,1,2,0,...
        for (int r = 0; r < 2 * NREQ; r++) begin
            for (int i = 0; i < NREQ; i++)
                if (!rvld[i]) begin new_req(i); rop[i] = 3'd0; end
            do_txn(0);
        end

        for (int t = 0; t < NTXN; t++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (rvld[i] && $urandom_range(0, 9) == 0) rvld[i] = 1'b0;
                else if (!rvld[i] && $urandom_range(0, 2) != 0) new_req(i);
            end
            do_txn(($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0);
        end

`ifdef FMA16_ARB_STATS_EN
        @(negedge clk);
        check("stat_ops", 32'(stat_ops), 32'(m_ops));
        check("stat_busy", 32'(stat_busy), 32'(m_busy));
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
